// File: rtl/exc_ctrl_pkg.sv
// exc_defs: shared definitions for the exception front end.
//   Cause codes written to CP0 ExcCode, CP0 status bit positions,
//   and the controller state encoding.
package exc_defs;
    localparam logic [4:0] INT = 5'd0;
    localparam logic [4:0] SYS = 5'd8;
    localparam logic [4:0] BP  = 5'd9;
    localparam logic [4:0] TR  = 5'd13;

    localparam int IE     = 0;
    localparam int SYS_EN = 1;
    localparam int BP_EN  = 2;
    localparam int TR_EN  = 3;
    localparam int IM_LSB = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HANDLER = 2'd2
    } state_t;
endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// irq_sync: multi-flop synchronizer followed by a rising-edge detector.
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   i_irq  - asynchronous interrupt line
//   o_rise - one-cycle pulse on a synchronized 0->1 transition
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    output logic o_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_irq};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt front end feeding the CP0 register file.
//   clk, rst              - clock, asynchronous active-low reset
//   instr_valid, pc       - decode-stage instruction valid and its address
//   syscall/brk/teq_taken - decoded synchronous trap requests
//   eret_in               - decoded eret
//   irq                   - asynchronous interrupt lines
//   status                - CP0 status (enables and interrupt masks)
//   exception, eret       - registered one-cycle pulses to CP0
//   cause, exc_pc         - ExcCode and EPC value, held between events
//   stall                 - freezes PC/decode while an event issues
//   irq_pending           - latched, not-yet-serviced interrupt edges
module exc_ctrl
    import exc_defs::*;
#(
    parameter int N_IRQ       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      pc,
    input  logic             syscall,
    input  logic             brk,
    input  logic             teq_taken,
    input  logic             eret_in,
    input  logic [N_IRQ-1:0] irq,
    input  logic [31:0]      status,
    output logic             exception,
    output logic             eret,
    output logic [4:0]       cause,
    output logic [31:0]      exc_pc,
    output logic             stall,
    output logic [N_IRQ-1:0] irq_pending
);
    state_t             r_state, w_next;
    logic               r_exception, r_eret;
    logic [4:0]         r_cause;
    logic [31:0]        r_exc_pc;
    logic [N_IRQ-1:0]   r_pending;
    logic [N_IRQ-1:0]   w_rise, w_int_vec, w_grant;
    logic               w_eval, w_sys, w_bp, w_tr, w_ret, w_int, w_sync, w_win;
    logic [4:0]         w_code;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst   (rst),
            .i_irq (irq[g]),
            .o_rise(w_rise[g])
        );
    end

    // Nothing is evaluated during ISSUE; decode is frozen by stall.
    assign w_eval    = r_state != ISSUE;
    assign w_sys     = w_eval & instr_valid & syscall & status[SYS_EN];
    assign w_bp      = w_eval & instr_valid & brk & status[BP_EN];
    assign w_tr      = w_eval & instr_valid & teq_taken & status[TR_EN];
    assign w_ret     = instr_valid & eret_in & (r_state == HANDLER);
    assign w_int_vec = r_pending & status[IM_LSB +: N_IRQ];
    assign w_int     = (r_state == IDLE) & status[IE] & |w_int_vec;
    assign w_sync    = w_ret | w_sys | w_bp | w_tr;
    assign w_win     = w_sync | w_int;
    assign w_code    = w_ret ? INT : w_sys ? SYS : w_bp ? BP : w_tr ? TR : INT;
    // Isolate the lowest set bit: only the winning line is cleared.
    assign w_grant   = (w_int & ~w_sync) ? (w_int_vec & (~w_int_vec + N_IRQ'(1))) : '0;
    assign stall     = w_win | (r_state == ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // The eret pulse is high exactly during ISSUE, so it tells where ISSUE returns to.
    always_comb begin
        w_next = r_state;
        if (r_state == ISSUE)
            w_next = r_eret ? IDLE : HANDLER;
        else if (w_win)
            w_next = ISSUE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exception <= 1'b0;
            r_eret      <= 1'b0;
            r_cause     <= '0;
            r_exc_pc    <= '0;
            r_pending   <= '0;
        end else begin
            r_exception <= w_win;
            r_eret      <= w_ret;
            // A fresh edge on the line being cleared keeps it pending.
            r_pending   <= (r_pending & ~w_grant) | w_rise;
            if (w_win) begin
                r_cause  <= w_code;
                r_exc_pc <= pc;
            end
        end
    end

    assign exception   = r_exception;
    assign eret        = r_eret;
    assign cause       = r_cause;
    assign exc_pc      = r_exc_pc;
    assign irq_pending = r_pending;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: table-driven self-checking bench for exc_ctrl with a scoreboard queue.
module tb_exc_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] pc;
    logic        syscall, brk, teq_taken, eret_in;
    logic [3:0]  irq;
    logic [31:0] status;
    logic        exception, eret, stall;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    logic [3:0]  irq_pending;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  trp;
        logic [31:0] pc;
        logic [3:0]  irq;
        logic [31:0] st;
        logic [2:0]  xf;
        logic [4:0]  xc;
        logic [31:0] xpc;
        logic [3:0]  xpend;
    } vec_t;

    typedef struct packed {
        logic        exc;
        logic        eret;
        logic [4:0]  cause;
        logic [31:0] pc;
        logic [3:0]  pend;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];

    exc_ctrl #(.N_IRQ(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .pc         (pc),
        .syscall    (syscall),
        .brk        (brk),
        .teq_taken  (teq_taken),
        .eret_in    (eret_in),
        .irq        (irq),
        .status     (status),
        .exception  (exception),
        .eret       (eret),
        .cause      (cause),
        .exc_pc     (exc_pc),
        .stall      (stall),
        .irq_pending(irq_pending)
    );

    always #5 clk = ~clk;

    // trp = {instr_valid, syscall, brk, teq_taken, eret_in}; xf = {stall, exception, eret}
    function automatic vec_t mk(logic [4:0] trp, logic [31:0] p, logic [3:0] iq, logic [31:0] st,
                                logic [2:0] xf, logic [4:0] xc, logic [31:0] xpc, logic [3:0] xpend);
        vec_t v;
        v.trp = trp; v.pc = p; v.irq = iq; v.st = st;
        v.xf = xf; v.xc = xc; v.xpc = xpc; v.xpend = xpend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        instr_valid = v.trp[4];
        {syscall, brk, teq_taken, eret_in} = v.trp[3:0];
        pc     = v.pc;
        irq    = v.irq;
        status = v.st;
        e.exc = v.xf[1]; e.eret = v.xf[0]; e.cause = v.xc; e.pc = v.xpc; e.pend = v.xpend;
        sb.push_back(e);
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(v.xf[2]));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".exception"}, 32'(exception), 32'(e.exc));
        chk({tag, ".eret"}, 32'(eret), 32'(e.eret));
        chk({tag, ".cause"}, 32'(cause), 32'(e.cause));
        chk({tag, ".exc_pc"}, exc_pc, e.pc);
        chk({tag, ".irq_pending"}, 32'(irq_pending), 32'(e.pend));
    endtask

    task automatic zero_inputs();
        instr_valid = 1'b0; pc = '0; syscall = 1'b0; brk = 1'b0;
        teq_taken = 1'b0; eret_in = 1'b0; irq = '0; status = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".exception"}, 32'(exception), 32'd0);
        chk({tag, ".eret"}, 32'(eret), 32'd0);
        chk({tag, ".cause"}, 32'(cause), 32'd0);
        chk({tag, ".exc_pc"}, exc_pc, 32'd0);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".irq_pending"}, 32'(irq_pending), 32'd0);
    endtask

    initial begin
        // syscall -> ISSUE -> HANDLER; eret -> IDLE; eret in IDLE ignored
        tv.push_back(mk(5'b11000, 32'h00400010, 4'h0, 32'h00F, 3'b110, 5'd8, 32'h00400010, 4'h0));
        tv.push_back(mk(5'b11000, 32'h00400010, 4'h0, 32'h00F, 3'b100, 5'd8, 32'h00400010, 4'h0));
        tv.push_back(mk(5'b00000, 32'h00400010, 4'h0, 32'h00F, 3'b000, 5'd8, 32'h00400010, 4'h0));
        tv.push_back(mk(5'b10001, 32'h00400100, 4'h0, 32'h00F, 3'b111, 5'd0, 32'h00400100, 4'h0));
        tv.push_back(mk(5'b10001, 32'h00400100, 4'h0, 32'h00F, 3'b100, 5'd0, 32'h00400100, 4'h0));
        tv.push_back(mk(5'b10001, 32'h00400100, 4'h0, 32'h00F, 3'b000, 5'd0, 32'h00400100, 4'h0));
        // irq[0] edge with IE set: pending after 3 edges, issue on the 4th
        tv.push_back(mk(5'b00000, 32'h00400200, 4'h1, 32'h101, 3'b000, 5'd0, 32'h00400100, 4'h0));
        tv.push_back(mk(5'b00000, 32'h00400200, 4'h1, 32'h101, 3'b000, 5'd0, 32'h00400100, 4'h0));
        tv.push_back(mk(5'b00000, 32'h00400200, 4'h1, 32'h101, 3'b000, 5'd0, 32'h00400100, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400200, 4'h1, 32'h101, 3'b110, 5'd0, 32'h00400200, 4'h0));
        tv.push_back(mk(5'b00000, 32'h00400200, 4'h1, 32'h101, 3'b100, 5'd0, 32'h00400200, 4'h0));
        tv.push_back(mk(5'b10001, 32'h00400204, 4'h1, 32'h101, 3'b111, 5'd0, 32'h00400204, 4'h0));
        tv.push_back(mk(5'b10001, 32'h00400204, 4'h1, 32'h101, 3'b100, 5'd0, 32'h00400204, 4'h0));
        // irq[0] edge with IE clear: stays pending, no exception
        tv.push_back(mk(5'b00000, 32'h00400204, 4'h0, 32'h100, 3'b000, 5'd0, 32'h00400204, 4'h0));
        tv.push_back(mk(5'b00000, 32'h00400204, 4'h1, 32'h100, 3'b000, 5'd0, 32'h00400204, 4'h0));
        tv.push_back(mk(5'b00000, 32'h00400204, 4'h1, 32'h100, 3'b000, 5'd0, 32'h00400204, 4'h0));
        tv.push_back(mk(5'b00000, 32'h00400204, 4'h1, 32'h100, 3'b000, 5'd0, 32'h00400204, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400204, 4'h1, 32'h100, 3'b000, 5'd0, 32'h00400204, 4'h1));
        // irq[2] pending, teq in the same cycle wins; interrupt issues after eret
        tv.push_back(mk(5'b00000, 32'h00400204, 4'h4, 32'h409, 3'b000, 5'd0, 32'h00400204, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400204, 4'h4, 32'h409, 3'b000, 5'd0, 32'h00400204, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400204, 4'h4, 32'h409, 3'b000, 5'd0, 32'h00400204, 4'h5));
        tv.push_back(mk(5'b10010, 32'h00400300, 4'h4, 32'h409, 3'b110, 5'd13, 32'h00400300, 4'h5));
        tv.push_back(mk(5'b10010, 32'h00400300, 4'h4, 32'h409, 3'b100, 5'd13, 32'h00400300, 4'h5));
        tv.push_back(mk(5'b00000, 32'h00400300, 4'h4, 32'h409, 3'b000, 5'd13, 32'h00400300, 4'h5));
        tv.push_back(mk(5'b10001, 32'h00400304, 4'h4, 32'h409, 3'b111, 5'd0, 32'h00400304, 4'h5));
        tv.push_back(mk(5'b10001, 32'h00400304, 4'h4, 32'h409, 3'b100, 5'd0, 32'h00400304, 4'h5));
        tv.push_back(mk(5'b00000, 32'h00400304, 4'h4, 32'h409, 3'b110, 5'd0, 32'h00400304, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400304, 4'h4, 32'h409, 3'b100, 5'd0, 32'h00400304, 4'h1));
        tv.push_back(mk(5'b10001, 32'h00400308, 4'h4, 32'h409, 3'b111, 5'd0, 32'h00400308, 4'h1));
        tv.push_back(mk(5'b10001, 32'h00400308, 4'h4, 32'h409, 3'b100, 5'd0, 32'h00400308, 4'h1));
        // disabled brk ignored; irq[1] and irq[3] together -> irq[1] first
        tv.push_back(mk(5'b10100, 32'h00400400, 4'h0, 32'hA01, 3'b000, 5'd0, 32'h00400308, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400400, 4'hA, 32'hA01, 3'b000, 5'd0, 32'h00400308, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400400, 4'hA, 32'hA01, 3'b000, 5'd0, 32'h00400308, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400400, 4'hA, 32'hA01, 3'b000, 5'd0, 32'h00400308, 4'hB));
        tv.push_back(mk(5'b00000, 32'h00400400, 4'hA, 32'hA01, 3'b110, 5'd0, 32'h00400400, 4'h9));
        tv.push_back(mk(5'b00000, 32'h00400400, 4'hA, 32'hA01, 3'b100, 5'd0, 32'h00400400, 4'h9));
        tv.push_back(mk(5'b10001, 32'h00400500, 4'hA, 32'hA01, 3'b111, 5'd0, 32'h00400500, 4'h9));
        tv.push_back(mk(5'b10001, 32'h00400500, 4'hA, 32'hA01, 3'b100, 5'd0, 32'h00400500, 4'h9));
        tv.push_back(mk(5'b00000, 32'h00400500, 4'hA, 32'hA01, 3'b110, 5'd0, 32'h00400500, 4'h1));
        tv.push_back(mk(5'b00000, 32'h00400500, 4'hA, 32'hA01, 3'b100, 5'd0, 32'h00400500, 4'h1));
        // nested traps in HANDLER: brk beats teq, syscall beats both
        tv.push_back(mk(5'b10110, 32'h00400610, 4'hA, 32'hA0F, 3'b110, 5'd9, 32'h00400610, 4'h1));
        tv.push_back(mk(5'b10110, 32'h00400610, 4'hA, 32'hA0F, 3'b100, 5'd9, 32'h00400610, 4'h1));
        tv.push_back(mk(5'b11110, 32'h00400620, 4'hA, 32'hA0F, 3'b110, 5'd8, 32'h00400620, 4'h1));

        rst = 1'b0;
        zero_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        foreach (tv[i]) apply($sformatf("v%0d", i), tv[i]);

        // asynchronous reset while in ISSUE
        rst = 1'b0;
        zero_inputs();
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply("post_rst_eret", mk(5'b10001, 32'h00400700, 4'h0, 32'h001, 3'b000, 5'd0, 32'h0, 4'h0));
        apply("post_rst_brk", mk(5'b10100, 32'h00400704, 4'h0, 32'h005, 3'b110, 5'd9, 32'h00400704, 4'h0));
        apply("post_rst_issue", mk(5'b10100, 32'h00400704, 4'h0, 32'h005, 3'b100, 5'd9, 32'h00400704, 4'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
